// File: rtl/vfu_pkg.sv
// -----------------------------------------------------------------------------
// vfu_pkg
// Shared types and constants for the vector functional unit.
//   state_t  : control FSM states
//   op_t     : opcode carried in cfg[OP_MSB:OP_LSB]
//   acc_width: width of the dot-product accumulator. It is sized so that
//              num_inputs full-width products can be summed without overflow.
// -----------------------------------------------------------------------------
package vfu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_VADD,
    OP_VMUL,
    OP_DOT,
    OP_VMAX
  } op_t;

  // Opcode field inside the config word; the bits above it are reserved.
  localparam int OP_LSB = 0;
  localparam int OP_MSB = 1;

  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

endpackage

// File: rtl/vfu_alu.sv
// -----------------------------------------------------------------------------
// vfu_alu
// Combinational single-element operation. The top steps one element through
// it per cycle.
//   a_i, b_i     : operand elements (width bits)
//   op_i         : operation select
//   acc_in_i     : running dot-product accumulator
//   elem_out_o   : per-element result (0 for DOT; DOT reports through acc)
//   acc_out_o    : next accumulator value (acc_in_i when not DOT)
// -----------------------------------------------------------------------------
module vfu_alu
  import vfu_pkg::*;
#(
  parameter int width = 16,
  parameter int acc_w = 34
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  input  op_t              op_i,
  input  logic [acc_w-1:0] acc_in_i,
  output logic [width-1:0] elem_out_o,
  output logic [acc_w-1:0] acc_out_o
);

  // Full unsigned product. VMUL keeps the low half and DOT accumulates all of it.
  logic [2*width-1:0] prod;
  assign prod = {{width{1'b0}}, a_i} * {{width{1'b0}}, b_i};

  always_comb begin
    elem_out_o = '0;
    acc_out_o  = acc_in_i;
    unique case (op_i)
      OP_VADD: elem_out_o = a_i + b_i;
      OP_VMUL: elem_out_o = prod[width-1:0];
      OP_DOT:  acc_out_o  = acc_in_i + acc_w'(prod);
      // On a signed tie, A wins.
      OP_VMAX: elem_out_o = ($signed(a_i) >= $signed(b_i)) ? a_i : b_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/vector_fu.sv
// -----------------------------------------------------------------------------
// vector_fu
// Vector functional unit placed after the tile register file. A go pulse
// triggers one full read of the register file: vectors A and B plus a config
// word. The unit then produces one result element per cycle and holds the
// result vector behind a valid/ready handshake.
//   clk, reset   : tile clock; synchronous active-high reset
//   go           : start request, dropped unless the FSM is idle
//   busy         : operation in flight (from accept until handshake)
//   ren          : register-file read enable; also blocks RF writes
//   r_data       : [0..n-1]=A, [n..2n-1]=B, [2n]=config word
//   r_data_vld   : read data valid, combinational on ren
//   res_data     : result vector
//   res_vld      : result valid
//   res_rdy      : consumer ready
// -----------------------------------------------------------------------------
module vector_fu
  import vfu_pkg::*;
#(
  parameter  int width        = 16,
  parameter  int num_inputs   = 4,
  localparam int total_inputs = num_inputs + num_inputs
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  go,
  output logic                                  busy,
  output logic                                  ren,
  input  logic [total_inputs:0][width-1:0]      r_data,
  input  logic                                  r_data_vld,
  output logic [num_inputs-1:0][width-1:0]      res_data,
  output logic                                  res_vld,
  input  logic                                  res_rdy
);

  localparam int ACC_W = acc_width(width, num_inputs);
  localparam int IDX_W = (num_inputs > 1) ? $clog2(num_inputs) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(num_inputs - 1);

  state_t                           state_q;
  logic                             ren_q, busy_q, vld_q;
  logic [num_inputs-1:0][width-1:0] a_q, b_q, res_q;
  op_t                              op_q;
  logic [IDX_W-1:0]                 idx_q;
  logic [ACC_W-1:0]                 acc_q;

  // ALU outputs for the current element.
  logic [width-1:0]                 elem_d;
  logic [ACC_W-1:0]                 acc_d;

  // Reserved config bits carry no meaning and are deliberately dropped.
  logic unused_cfg;
  assign unused_cfg = ^r_data[total_inputs][width-1:OP_MSB+1];

  vfu_alu #(
    .width (width),
    .acc_w (ACC_W)
  ) u_alu (
    .a_i        (a_q[idx_q]),
    .b_i        (b_q[idx_q]),
    .op_i       (op_q),
    .acc_in_i   (acc_q),
    .elem_out_o (elem_d),
    .acc_out_o  (acc_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= OP_VADD;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            state_q <= LOAD;
            ren_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          // Snapshot the operands so that later RF writes cannot disturb this op.
          if (r_data_vld) begin
            for (int i = 0; i < num_inputs; i++) begin
              a_q[i] <= r_data[i];
              b_q[i] <= r_data[num_inputs+i];
            end
            op_q    <= op_t'(r_data[total_inputs][OP_MSB:OP_LSB]);
            ren_q   <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          // Results are written in place. For DOT, elem_d is 0, so the upper
          // lanes end at zero; lane 0 takes the final accumulator below.
          res_q[idx_q] <= elem_d;
          acc_q        <= acc_d;
          if (idx_q == IDX_LAST) begin
            state_q <= DONE;
            vld_q   <= 1'b1;
            if (op_q == OP_DOT) res_q[0] <= acc_d[width-1:0];
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (res_rdy) begin
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign ren      = ren_q;
  assign res_vld  = vld_q;
  assign res_data = res_q;

endmodule

// File: tb/tb_vector_fu.sv
module tb_vector_fu;
  localparam int W = 16;
  localparam int N = 4;
  localparam int T = 2 * N;
  localparam longint MOD = 65536;
  typedef logic [N-1:0][W-1:0] vec_t;

  logic clk = 1'b0;
  logic reset, go, busy, ren, r_data_vld, res_vld, res_rdy, vld_en;
  logic [T:0][W-1:0] rf;
  vec_t res_data;

  assign r_data_vld = ren & vld_en;

  vector_fu #(.width(W), .num_inputs(N)) dut (
    .clk(clk), .reset(reset), .go(go), .busy(busy), .ren(ren),
    .r_data(rf), .r_data_vld(r_data_vld), .res_data(res_data),
    .res_vld(res_vld), .res_rdy(res_rdy)
  );

  always #5 clk = ~clk;

  // Expected outputs after the most recent active edge.
  logic exp_ren, exp_busy, exp_vld, exp_zero;
  vec_t exp_res;
  bit   chk_en = 1'b0;
  bit   pins_done = 1'b0;
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v[0] = W'(e0); v[1] = W'(e1); v[2] = W'(e2); v[3] = W'(e3);
    return v;
  endfunction

  // Reference model: the whole result vector computed in one pass.
  function automatic vec_t model(input vec_t a, input vec_t b, input logic [W-1:0] cfg);
    vec_t   r = '0;
    longint acc = 0;
    int     sa, sb;
    for (int i = 0; i < N; i++) begin
      case (cfg[1:0])
        2'd0: r[i] = W'((longint'(a[i]) + longint'(b[i])) % MOD);
        2'd1: r[i] = W'((longint'(a[i]) * longint'(b[i])) % MOD);
        2'd2: acc = acc + longint'(a[i]) * longint'(b[i]);
        default: begin
          sa = int'(a[i]); if (sa >= 32768) sa = sa - 65536;
          sb = int'(b[i]); if (sb >= 32768) sb = sb - 65536;
          r[i] = (sa >= sb) ? a[i] : b[i];
        end
      endcase
    end
    if (cfg[1:0] == 2'd2) r[0] = W'(acc % MOD);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // The only compare process. On its first pass it pins the model against
  // hand-computed vectors; after that it checks every cycle.
  always @(negedge clk) begin
    if (!pins_done) begin
      pins_done = 1'b1;
      chk("pin_vadd", model(mk(1,2,'hFFFF,'h8000), mk(1,2,1,'h8000), 16'h0000), mk(2,4,0,0));
      chk("pin_dot", model(mk(1,2,3,4), mk(5,6,7,8), 16'h0002), mk(70,0,0,0));
      chk("pin_dot_ovf", model(mk('hFFFF,'hFFFF,'hFFFF,'hFFFF), mk('hFFFF,'hFFFF,'hFFFF,'hFFFF), 16'h0002), mk(4,0,0,0));
      chk("pin_vmax", model(mk('h7FFF,'hFFFF,5,'h8000), mk('h8000,1,5,'h8001), 16'hFFC3), mk('h7FFF,1,5,'h8001));
      chk("pin_vmul", model(mk(3,'h100,0,7), mk(4,'h100,9,7), 16'h0001), mk(12,0,0,49));
    end
    if (chk_en) begin
      chk("ren", ren, exp_ren);
      chk("busy", busy, exp_busy);
      chk("res_vld", res_vld, exp_vld);
      if (exp_vld || exp_zero)
        for (int i = 0; i < N; i++)
          chk($sformatf("res_data[%0d]", i), res_data[i], exp_res[i]);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One full operation. stall = cycles with r_data_vld low in LOAD, rdy_dly =
  // cycles res_rdy is held low once valid. go is pulsed at points where it must
  // be ignored.
  task automatic run_op(input vec_t a, input vec_t b, input logic [W-1:0] cfg,
                        input vec_t expv, input int stall, input int rdy_dly,
                        input bit go_stall, input bit go_hs);
    for (int i = 0; i < N; i++) begin rf[i] = a[i]; rf[N+i] = b[i]; end
    rf[T]    = cfg;
    exp_zero = 1'b0;
    res_rdy  = (rdy_dly == 0);
    vld_en   = (stall == 0);
    go = 1'b1; tick(); go = 1'b0;
    exp_ren = 1'b1; exp_busy = 1'b1;
    for (int s = 0; s < stall; s++) begin
      go = 1'($urandom_range(0, 1)); tick(); go = 1'b0;
    end
    vld_en = 1'b1;
    tick();
    exp_ren = 1'b0; vld_en = 1'b0;
    // Change the register file now: the result must not notice.
    for (int i = 0; i <= T; i++) rf[i] = W'($urandom);
    for (int k = 0; k < N; k++) begin
      go = 1'($urandom_range(0, 1)); tick();
    end
    go = 1'b0;
    exp_vld = 1'b1; exp_res = expv;
    for (int d = 0; d < rdy_dly; d++) begin
      go = go_stall && (d == rdy_dly / 2); tick(); go = 1'b0;
    end
    res_rdy = 1'b1; go = go_hs;
    tick();
    go = 1'b0; res_rdy = 1'b0;
    exp_vld = 1'b0; exp_busy = 1'b0;
    tick();
  endtask

  task automatic rand_op();
    vec_t a, b;
    logic [W-1:0] cfg;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 5))
        0: a[i] = 16'hFFFF;
        1: a[i] = 16'h8000;
        default: a[i] = W'($urandom);
      endcase
      b[i] = ($urandom_range(0, 5) == 0) ? a[i] : W'($urandom);
    end
    cfg = W'($urandom);
    run_op(a, b, cfg, model(a, b, cfg), $urandom_range(0, 2), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; go = 1'b0; res_rdy = 1'b0; vld_en = 1'b0; rf = '0;
    exp_ren = 1'b0; exp_busy = 1'b0; exp_vld = 1'b0; exp_zero = 1'b1; exp_res = '0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Directed cases
    run_op(mk(1,2,'hFFFF,'h8000), mk(1,2,1,'h8000), 16'h0000, mk(2,4,0,0), 0, 0, 0, 0);
    run_op(mk(1,2,3,4), mk(5,6,7,8), 16'h0002, mk(70,0,0,0), 0, 0, 0, 0);
    run_op(mk('hFFFF,'hFFFF,'hFFFF,'hFFFF), mk('hFFFF,'hFFFF,'hFFFF,'hFFFF), 16'h0002, mk(4,0,0,0), 0, 0, 0, 1);
    run_op(mk('h7FFF,'hFFFF,5,'h8000), mk('h8000,1,5,'h8001), 16'hFFC3, mk('h7FFF,1,5,'h8001), 0, 0, 0, 0);
    run_op(mk(3,'h100,0,7), mk(4,'h100,9,7), 16'h0001, mk(12,0,0,49), 0, 10, 1, 0);
    run_op(mk(10,20,30,40), mk(1,2,3,4), 16'h0000, mk(11,22,33,44), 2, 0, 0, 0);

    // Randomized operations
    for (int n = 0; n < 40; n++) rand_op();

    // Reset during COMPUTE aborts the op and clears everything.
    for (int i = 0; i < N; i++) begin rf[i] = W'($urandom); rf[N+i] = W'($urandom); end
    rf[T] = 16'h0001;
    vld_en = 1'b1; res_rdy = 1'b1;
    go = 1'b1; tick(); go = 1'b0;
    exp_ren = 1'b1; exp_busy = 1'b1;
    tick();
    exp_ren = 1'b0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    vld_en = 1'b0;
    exp_busy = 1'b0; exp_vld = 1'b0; exp_ren = 1'b0; exp_res = '0; exp_zero = 1'b1;
    repeat (8) tick();
    res_rdy = 1'b0;

    // The unit recovers after the abort.
    run_op(mk(1,2,3,4), mk(5,6,7,8), 16'h0003, mk(5,6,7,8), 1, 1, 0, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
